// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types, widths and saturating-add helper for adder_share_sched
//
// Contents:
//   DATA_W        datapath width of the shared adder and the accumulators
//   sched_state_t scheduler FSM states
//   sat_add8      overflow check / clamp on the adder result (used when ADD_SAT_EN is defined)
package adder_sched_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } sched_state_t;

    // Returns {overflow, clamped_sum}. An unsigned add overflowed exactly when
    // the wrapped sum is smaller than one of its operands.
    function automatic logic [DATA_W:0] sat_add8(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] sum);
        logic ovf;
        ovf = (sum < a);
        return {ovf, (ovf ? {DATA_W{1'b1}} : sum)};
    endfunction

endpackage

// File: rtl/adder_share_sched_rr_arbiter.sv
// rtl/adder_share_sched_rr_arbiter.sv - combinational rotate-priority (round-robin) arbiter
//
// Parameters:
//   N        number of requesters
//   IW       index width, $clog2(N)
// Ports:
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index for this decision
//   win      out  IW   granted index (0 when no request)
//   any_req  out  1    at least one request is present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          any_req
);

    logic [IW-1:0] idx;

    // Scan from the lowest priority (ptr+N-1) up to ptr so the last hit,
    // i.e. the one closest to ptr, is the grant.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - time-shares one slow external 8-bit adder among N_REQ accumulators
//
// Optional feature macro: ADD_SAT_EN (saturating add plus 'sat' output port).
//
// Parameters:
//   N_REQ          number of requesters (2..8)
//   SETTLE_CYCLES  clk cycles the external adder needs to settle (>=1)
// Ports:
//   clk      in   1               rising-edge clock
//   reset    in   1               synchronous, active-high
//   req      in   N_REQ           per-requester request, held until ack
//   operand  in   8*N_REQ         flat operand bus, slice i = operand[8*i+:8]
//   clr      in   N_REQ           synchronous clear of accumulator i
//   add_a    out  8               adder operand A (granted operand)
//   add_b    out  8               adder operand B (granted accumulator)
//   add_sum  in   8               adder result
//   ack      out  1               one-cycle completion pulse
//   ack_id   out  $clog2(N_REQ)   requester served by ack
//   result   out  8               new accumulator value of ack_id, valid with ack
//   busy     out  1               operation in flight (settling or acknowledging)
//   sat      out  1               (ADD_SAT_EN only) result was clamped, valid with ack
module adder_share_sched
    import adder_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int IW            = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [DATA_W*N_REQ-1:0] operand,
    input  logic [N_REQ-1:0]        clr,
    output logic [DATA_W-1:0]       add_a,
    output logic [DATA_W-1:0]       add_b,
    input  logic [DATA_W-1:0]       add_sum,
    output logic                    ack,
    output logic [IW-1:0]           ack_id,
    output logic [DATA_W-1:0]       result,
`ifdef ADD_SAT_EN
    output logic                    sat,
`endif
    output logic                    busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     gid_q;
    logic [IW-1:0]     ptr_q;
    logic [DATA_W-1:0] add_a_q, add_b_q;
    logic [DATA_W-1:0] result_q;
    logic [IW-1:0]     ack_id_q;
    logic [DATA_W-1:0] acc_q [N_REQ];

    logic [IW-1:0]     win;
    logic              any_req;
    logic [IW-1:0]     next_ptr;
    logic              grant;
    logic              capture;
    logic [DATA_W-1:0] sum_w;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .any_req (any_req)
    );

    assign next_ptr = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;

`ifdef ADD_SAT_EN
    logic sat_w;
    logic sat_q;
    assign {sat_w, sum_w} = sat_add8(add_a_q, add_sum);
    assign sat            = sat_q & ack;
`else
    assign sum_w = add_sum;
`endif

    // Next-state logic; grant/capture are the single-cycle strobes that load
    // the datapath registers below.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gid_q    <= '0;
            ptr_q    <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            result_q <= '0;
            ack_id_q <= '0;
`ifdef ADD_SAT_EN
            sat_q    <= 1'b0;
`endif
            for (int i = 0; i < N_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Operands are frozen from grant until the next grant so the
            // adder inputs never move inside the settle window.
            if (grant) begin
                add_a_q <= operand[DATA_W*win +: DATA_W];
                add_b_q <= acc_q[win];
                gid_q   <= win;
                ptr_q   <= next_ptr;
            end
            if (capture) begin
                result_q <= sum_w;
                ack_id_q <= gid_q;
`ifdef ADD_SAT_EN
                sat_q    <= sat_w;
`endif
            end
            // A clear coincident with capture wins; result still reports the sum.
            for (int i = 0; i < N_REQ; i++) begin
                if (clr[i]) begin
                    acc_q[i] <= '0;
                end else if (capture && (gid_q == IW'(i))) begin
                    acc_q[i] <= sum_w;
                end
            end
        end
    end

    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign result = result_q;
    assign ack_id = ack_id_q;
    assign ack    = (state_q == S_DONE);
    assign busy   = (state_q == S_WAIT) || (state_q == S_DONE);

endmodule

// File: tb/tb_adder_share_sched.sv
// tb/tb_adder_share_sched.sv - randomized self-checking bench for adder_share_sched
module tb_adder_share_sched;

    localparam int N = 4;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] operand;
    logic [3:0]  clr;
    logic [7:0]  add_a, add_b, add_sum, result;
    logic        ack, busy;
    logic [1:0]  ack_id;
`ifdef ADD_SAT_EN
    logic        sat;
`endif

    adder_share_sched #(.N_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .operand (operand),
        .clr     (clr),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .ack     (ack),
        .ack_id  (ack_id),
        .result  (result),
`ifdef ADD_SAT_EN
        .sat     (sat),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External slow adder.
    assign #32 add_sum = add_a + add_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_acc [4];
    int         m_ptr;
    bit         m_sat;

    bit         stab_on;
    logic [7:0] stab_a, stab_b;
    int         clr_at;
    logic [3:0] clr_bits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_pick(input logic [3:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_add(input int id, input logic [7:0] op);
        int s;
        s = int'(m_acc[id]) + int'(op);
        m_sat = 1'b0;
`ifdef ADD_SAT_EN
        if (s > 255) begin
            s     = 255;
            m_sat = 1'b1;
        end
`endif
        return s[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_acc[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        clr     = '0;
        operand = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Counts falling edges until ack; optionally checks adder-input
    // stability while scrambling the operand bus, and fires clr at cycle clr_at.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            clr = (n == clr_at) ? clr_bits : 4'b0000;
            if (stab_on) begin
                check("stab_add_a", add_a, stab_a);
                check("stab_add_b", add_b, stab_b);
                operand = $urandom;
            end
            if (ack) begin
                cyc = n;
                break;
            end
        end
        clr = '0;
        if (cyc == 0) check("ack_timeout", 0, 1);
    endtask

    // One isolated operation from idle using the current operand bus.
    task automatic op_round(input logic [3:0] mask, input bit stab);
        int         w, cyc;
        logic [7:0] exp;
        bit         exp_sat;
        w       = m_pick(mask);
        exp     = m_add(w, operand[8*w +: 8]);
        exp_sat = m_sat;
        stab_a  = operand[8*w +: 8];
        stab_b  = m_acc[w];
        stab_on = stab;
        req     = mask;
        wait_ack(cyc);
        stab_on = 1'b0;
        check("latency", cyc, S + 1);
        check("ack_id", ack_id, w);
        check("result", result, exp);
`ifdef ADD_SAT_EN
        check("sat", sat, exp_sat);
`endif
        m_acc[w] = exp;
        if (clr_at != 0 && clr_bits[w]) m_acc[w] = 8'h00;
        m_ptr   = (w + 1) % N;
        req     = '0;
        clr_at  = 0;
        @(negedge clk);
        check("ack_pulse", ack, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic single_op(input int id, input logic [7:0] op);
        operand[8*id +: 8] = op;
        op_round(4'b0001 << id, 1'b1);
    endtask

    task automatic idle_clear(input logic [3:0] bits);
        clr = bits;
        @(negedge clk);
        clr = '0;
        for (int i = 0; i < N; i++) if (bits[i]) m_acc[i] = 8'h00;
    endtask

    initial begin
        int         cyc, w;
        logic [7:0] exp;
        logic [3:0] mask;
        stab_on  = 1'b0;
        clr_at   = 0;
        clr_bits = '0;
        do_reset();
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_ack_id", ack_id, 0);
        check("rst_result", result, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_busy", busy, 0);

        // Single ops on requester 0.
        single_op(0, 8'h05);
        single_op(0, 8'h03);

        // Round robin with all requests held.
        do_reset();
        operand = {8'd4, 8'd3, 8'd2, 8'd1};
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w   = m_pick(4'b1111);
            exp = m_add(w, operand[8*w +: 8]);
            wait_ack(cyc);
            check("rr_spacing", cyc, (k == 0) ? S + 1 : S + 2);
            check("rr_ack_id", ack_id, w);
            check("rr_result", result, exp);
            m_acc[w] = exp;
            m_ptr    = (w + 1) % N;
        end
        req = '0;
        @(negedge clk);

        // Wrap / saturate.
        idle_clear(4'b0100);
        single_op(2, 8'hF0);
        single_op(2, 8'h20);

        // Clear coincident with capture.
        idle_clear(4'b0010);
        clr_bits = 4'b0010;
        clr_at   = S;
        single_op(1, 8'h09);
        single_op(1, 8'h01);

        // Reset two cycles into the settle window.
        operand[7:0] = 8'h05;
        req          = 4'b0001;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("midrst_ack", ack, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        reset = 1'b0;
        model_reset();
        single_op(3, 8'h07);

        // Randomized operations with occasional idle clears.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) idle_clear(4'($urandom_range(0, 15)));
            mask    = 4'($urandom_range(1, 15));
            operand = $urandom;
            op_round(mask, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
